// File: rtl/target_locator.sv
// Colour-window target locator: classifies pixels against a shadowed RGB window and publishes a
// per-frame bounding box and count. The stream is forwarded 2 clocks late; TARGET_OVERLAY_EN draws the box.
module target_locator #(
  parameter int H_ACT   = 1280,
  parameter int V_ACT   = 720,
  parameter int MIN_PIX = 64,
  localparam int XW = $clog2(H_ACT),
  localparam int YW = $clog2(V_ACT),
  localparam int PW = 3*8 + 4 + XW + YW,
  localparam int CW = $clog2(H_ACT*V_ACT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] i_pack,
  input  logic          en,
  input  logic [23:0]   th_lo,
  input  logic [23:0]   th_hi,
  output logic [PW-1:0] o_pack,
  output logic [XW-1:0] box_x0,
  output logic [XW-1:0] box_x1,
  output logic [YW-1:0] box_y0,
  output logic [YW-1:0] box_y1,
  output logic [CW-1:0] box_cnt,
  output logic          box_valid,
  output logic          box_upd,
  output logic [1:0]    fsm_state
);

  // Packed field offsets, LSB first: y, x, b, g, r, de, vsync, hsync, clk.
  localparam int PY  = 0;
  localparam int PX  = YW;
  localparam int PB  = YW + XW;
  localparam int PG  = PB + 8;
  localparam int PR  = PG + 8;
  localparam int PDE = PR + 8;
  localparam int PVS = PDE + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, ACCUM = 2'd2} state_t;

  state_t        state;
  logic [PW-1:0] s1_pack;
  logic          s1_match;
  logic          vs2;
  logic [23:0]   sh_lo, sh_hi;
  logic [23:0]   lo_eff, hi_eff;
  logic [7:0]    in_r, in_g, in_b;
  logic          hit, fs;
  logic [XW-1:0] s1_x, min_x, max_x;
  logic [YW-1:0] s1_y, min_y, max_y;
  logic [CW-1:0] cnt;
  logic          acc_clr, acc_inc, publish, outline;

  assign fsm_state = state;
  assign s1_x = s1_pack[PX +: XW];
  assign s1_y = s1_pack[PY +: YW];
  // Frame start is the vsync rising edge seen on the stage-1 copy.
  assign fs = s1_pack[PVS] & ~vs2;

  // The window for the pixel entering stage 1 during a frame start already belongs to the new frame.
  always_comb begin
    lo_eff = fs ? th_lo : sh_lo;
    hi_eff = fs ? th_hi : sh_hi;
    in_r   = i_pack[PR +: 8];
    in_g   = i_pack[PG +: 8];
    in_b   = i_pack[PB +: 8];
    hit    = i_pack[PDE]
          && (in_r >= lo_eff[23:16]) && (in_r <= hi_eff[23:16])
          && (in_g >= lo_eff[15:8])  && (in_g <= hi_eff[15:8])
          && (in_b >= lo_eff[7:0])   && (in_b <= hi_eff[7:0]);
  end

  // No backpressure: one pixel enters and one leaves every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_pack  <= '0;
      s1_match <= 1'b0;
      vs2      <= 1'b0;
      sh_lo    <= '0;
      sh_hi    <= '0;
    end else begin
      s1_pack  <= i_pack;
      s1_match <= hit;
      vs2      <= s1_pack[PVS];
      if (fs) begin
        sh_lo <= th_lo;
        sh_hi <= th_hi;
      end
    end
  end

`ifdef TARGET_OVERLAY_EN
  logic in_xr, in_yr;
  always_comb begin
    in_xr   = (s1_x >= box_x0) && (s1_x <= box_x1);
    in_yr   = (s1_y >= box_y0) && (s1_y <= box_y1);
    outline = box_valid && ((in_xr && (s1_y == box_y0 || s1_y == box_y1)) ||
                            (in_yr && (s1_x == box_x0 || s1_x == box_x1)));
  end
`else
  assign outline = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_pack <= '0;
    else if (outline) o_pack <= {s1_pack[PW-1:PDE], 24'hFF0000, s1_pack[PB-1:0]};
    else o_pack <= s1_pack;
  end

  // A pixel sitting in stage 1 during a frame start is dropped from both frames.
  assign acc_clr = !en || (state != ACCUM) || fs;
  assign acc_inc = !acc_clr && s1_match;
  assign publish = en && (state == ACCUM) && fs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_x <= XW'(H_ACT - 1);
      max_x <= '0;
      min_y <= YW'(V_ACT - 1);
      max_y <= '0;
      cnt   <= '0;
    end else if (acc_clr) begin
      min_x <= XW'(H_ACT - 1);
      max_x <= '0;
      min_y <= YW'(V_ACT - 1);
      max_y <= '0;
      cnt   <= '0;
    end else if (acc_inc) begin
      if (s1_x < min_x) min_x <= s1_x;
      if (s1_x > max_x) max_x <= s1_x;
      if (s1_y < min_y) min_y <= s1_y;
      if (s1_y > max_y) max_y <= s1_y;
      if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      box_x0    <= '0;
      box_x1    <= '0;
      box_y0    <= '0;
      box_y1    <= '0;
      box_cnt   <= '0;
      box_valid <= 1'b0;
      box_upd   <= 1'b0;
    end else begin
      box_upd <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= ARM;
          ARM:     if (fs) state <= ACCUM;
          ACCUM:   state <= ACCUM;
          default: state <= IDLE;
        endcase
      end
      if (publish) begin
        box_cnt <= cnt;
        box_upd <= 1'b1;
        if (cnt >= CW'(MIN_PIX)) begin
          box_x0    <= min_x;
          box_x1    <= max_x;
          box_y0    <= min_y;
          box_y1    <= max_y;
          box_valid <= 1'b1;
        end else begin
          box_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/target_locator.md
# target_locator

Per-frame colour-window target locator that sits directly downstream of the white-balance stage and consumes its packed pixel stream. Each pixel is classified against a programmable inclusive RGB window. Matching pixels are accumulated into a bounding box and a pixel count, which are published once per frame. The pixel stream is forwarded with fixed latency, optionally with the last box drawn on it.

## Interface

Parameters:
- `H_ACT`, 1280, active pixels per line; x width is `XW=$clog2(H_ACT)`.
- `V_ACT`, 720, active lines per frame; y width is `YW=$clog2(V_ACT)`.
- `MIN_PIX`, 64, minimum matching pixels for a frame's box to be declared valid.

Ports:
- `clk`, in, 1, pixel clock; identical to the clock carried in `i_pack`.
- `rst`, in, 1, reset; asynchronous, active-high.
- `i_pack`, in, `3*8+4+XW+YW`, packed stream {clk, hsync, vsync, de, r, g, b, x, y}, using the standard unpack/pack helpers.
- `en`, in, 1, locator enable.
- `th_lo`, in, 24, window low bounds {r, g, b}, inclusive.
- `th_hi`, in, 24, window high bounds {r, g, b}, inclusive.
- `o_pack`, out, same width as `i_pack`, forwarded stream.
- `box_x0`, `box_x1`, out, XW, left and right column of the last valid box.
- `box_y0`, `box_y1`, out, YW, top and bottom row of the last valid box.
- `box_cnt`, out, `CW=$clog2(H_ACT*V_ACT+1)`, matching-pixel count of the last completed frame.
- `box_valid`, out, 1, the last completed frame had `box_cnt >= MIN_PIX`.
- `box_upd`, out, 1, one-cycle pulse when the box outputs update.

## Operation

- Frame start: rising edge of vsync, detected on the stage-1 (one-cycle-delayed) copy of vsync.
- Shadowing: `th_lo`/`th_hi` are copied into shadow registers at each frame start. Mid-frame threshold changes have no effect until the next frame.
- Match (stage 1, registered): `de && lo_c <= c <= hi_c` for each of r, g, b. If `lo_c > hi_c` for any channel, nothing matches.
- Accumulate (stage 2), on each match:
  - `min_x = min(min_x, x)`, `max_x = max(max_x, x)`, `min_y = min(min_y, y)`, `max_y = max(max_y, y)`.
  - `cnt` increments and saturates at all-ones.
- Accumulator init values: `min_x = H_ACT-1`, `max_x = 0`, `min_y = V_ACT-1`, `max_y = 0`, `cnt = 0`.
- State machine:
  - IDLE: accumulators held at init. `en=1` moves to ARM.
  - ARM: waits for a frame start; the partial frame in progress is discarded. Frame start moves to ACCUM, accumulators at init.
  - ACCUM: accumulates. At each frame start it publishes, re-initialises the accumulators and stays in ACCUM. `en=0` in any state moves to IDLE immediately; the partial frame is discarded and nothing is published.
- Publish, on a frame start while in ACCUM:
  - `box_cnt <= cnt` and `box_upd` pulses.
  - If `cnt >= MIN_PIX`: box outputs load min/max and `box_valid <= 1`.
  - Otherwise: box coordinates hold their previous values and `box_valid <= 0`.
- Boundary cases:
  - A pixel with `de` asserted in the same stage-2 cycle as a frame start is dropped; it is not counted in either frame.
  - A single matching pixel gives `x0 == x1` and `y0 == y1`.
  - `en` rising in the frame-start cycle goes to ARM; ACCUM starts at the following frame start.

## Timing

- Reset values: every box output 0, `box_valid=0`, `box_upd=0`, `o_pack=0`, state IDLE, shadows 0.
- `o_pack` = `i_pack` delayed exactly 2 clocks, with sync, de, x and y aligned.
- Box outputs and `box_upd` change 2 clocks after `i_vsync` rises. `box_upd` is high for exactly 1 clock.
- No backpressure; one pixel per clock is accepted continuously.
- An asserted `rst` mid-frame returns to IDLE immediately. The first publish after release is at the second frame start once `en=1`.

## Configuration

- `TARGET_OVERLAY_EN` defined: when `box_valid=1`, output pixels on the 1-pixel outline of the published box are forced to r=255, g=0, b=0. An outline pixel has (x in [x0,x1] and y==y0 or y==y1) or (y in [y0,y1] and x==x0 or x==x1). Latency is unchanged at 2.
- Not defined: `o_pack` RGB is the delayed input, unmodified.

## Test plan

- Window {200..255, 0..50, 0..50}, red square x=100..149, y=300..349 on black, `en=1`, 3 frames.
  - Expected from frame 2 onward: `box_upd` pulses, x0=100, x1=149, y0=300, y1=349, cnt=2500, `box_valid=1`.
- 10 matching pixels with `MIN_PIX=64`.
  - Expected: cnt=10, `box_valid=0`, previous coordinates held.
- `en` dropped mid-frame, then raised again.
  - Expected: no `box_upd` for the partial frame.
  - Expected: the first `box_upd` comes at the second frame start after re-enable.
- `th_hi` changed mid-frame.
  - Expected: the current frame still uses the old window; the new window applies from the next frame.
- `rst` pulsed mid-frame.
  - Expected: all outputs 0 within the reset cycle, and `o_pack` 0 until 2 clocks after release.
- With `TARGET_OVERLAY_EN` and the square above.
  - Expected: the pixel at (100,320) outputs 255/0/0 and the pixel at (120,320) passes through unchanged.
